// File: rtl/instr_reg_pkg.sv
// rtl/instr_reg_pkg.sv - shared types, defaults and packing helper for the instruction register array
//
// Purpose : opcode enumeration, default geometry constants and a helper that
//           builds an instruction word {opcode, operand_a, operand_b} at the
//           default widths.
// Ports   : none (package).
package instr_reg_pkg;

  localparam int OPC_W_DEFAULT = 5;
  localparam int OP_W_DEFAULT  = 32;
  localparam int DEPTH_DEFAULT = 32;
  localparam int IW_DEFAULT    = OPC_W_DEFAULT + 2 * OP_W_DEFAULT;

  typedef enum logic [OPC_W_DEFAULT-1:0] {
    OPC_NOP = 5'h00,
    OPC_ADD = 5'h01,
    OPC_SUB = 5'h02,
    OPC_AND = 5'h03,
    OPC_OR  = 5'h04,
    OPC_LD  = 5'h08,
    OPC_ST  = 5'h09,
    OPC_JMP = 5'h10
  } opcode_t;

  function automatic logic [IW_DEFAULT-1:0] pack_instr(
    input opcode_t                 opc,
    input logic [OP_W_DEFAULT-1:0] a,
    input logic [OP_W_DEFAULT-1:0] b
  );
    return {opc, a, b};
  endfunction

endpackage

// File: rtl/instr_reg_array_rd_port.sv
// rtl/instr_reg_array_rd_port.sv - one registered read channel of the instruction register array
//
// Purpose : range-checks the read index, selects the entry and its valid bit,
//           optionally forwards a same-cycle write/clear, and registers the
//           result (1-cycle latency).
// Macro   : INSTR_REG_WRITE_BYPASS_EN enables write/clear forwarding.
// Ports   : clk, reset       - clock, async active-high reset
//           rd_en_i          - read request for this channel
//           rd_ptr_i         - read index
//           mem_i, vld_i     - current storage contents and valid bits
//           wr_en_i, wr_ptr_i, wr_word_i, clear_i - write side (bypass build only)
//           word_o, valid_o  - registered read data and valid
module instr_reg_rd_port #(
  parameter int DEPTH = 32,
  parameter int PW    = 5,
  parameter int IW    = 69
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en_i,
  input  logic [PW-1:0]             rd_ptr_i,
  input  logic [DEPTH-1:0][IW-1:0]  mem_i,
  input  logic [DEPTH-1:0]          vld_i,
`ifdef INSTR_REG_WRITE_BYPASS_EN
  input  logic                      wr_en_i,
  input  logic [PW-1:0]             wr_ptr_i,
  input  logic [IW-1:0]             wr_word_i,
  input  logic                      clear_i,
`endif
  output logic [IW-1:0]             word_o,
  output logic                      valid_o
);

  logic          in_range;
  logic [PW-1:0] safe_ptr;
  logic [IW-1:0] sel_word;
  logic          sel_vld;
  logic [IW-1:0] word_d, word_q;
  logic          valid_d, valid_q;

  // A power-of-two depth makes every index legal, so no comparator is built.
  if ((1 << PW) == DEPTH) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);
    assign in_range = ({1'b0, rd_ptr_i} < DEPTH_L);
  end

  // Keep the array select inside bounds; the result is discarded when out of range.
  assign safe_ptr = in_range ? rd_ptr_i : '0;

  always_comb begin
    sel_word = mem_i[safe_ptr];
    sel_vld  = vld_i[safe_ptr] & in_range;
`ifdef INSTR_REG_WRITE_BYPASS_EN
    // clear_all wins over a concurrent write, mirroring the storage update.
    if (clear_i) begin
      sel_vld = 1'b0;
    end else if (wr_en_i && in_range && (wr_ptr_i == rd_ptr_i)) begin
      sel_word = wr_word_i;
      sel_vld  = 1'b1;
    end
`endif
    word_d  = word_q;
    valid_d = 1'b0;
    if (rd_en_i) begin
      word_d  = in_range ? sel_word : '0;
      valid_d = sel_vld;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o  = word_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_reg_array.sv
// rtl/instr_reg_array.sv - DEPTH-entry instruction word array with NUM_RD registered read channels
//
// Purpose : stores {opcode, operand_a, operand_b} words with per-entry valid
//           bits and a live occupancy count; clear_all invalidates everything
//           in one cycle and beats a simultaneous write.
// Macro   : INSTR_REG_WRITE_BYPASS_EN forwards same-cycle writes/clears to readers.
// Ports   : clk, reset                   - clock, async active-high reset
//           load_en, write_pointer       - write strobe and index
//           opcode, operand_a, operand_b - write data fields (MSB to LSB)
//           clear_all                    - invalidate all entries
//           rd_en, read_pointer          - per-channel request and packed indices
//           instruction_word, valid      - per-channel registered read data / valid
//           num_valid                    - number of valid entries
module instr_reg_array
  import instr_reg_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int OP_W   = OP_W_DEFAULT,
  parameter int OPC_W  = OPC_W_DEFAULT,
  parameter int NUM_RD = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int IW    = OPC_W + 2 * OP_W,
  localparam int NVW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [PW-1:0]        write_pointer,
  input  logic [OPC_W-1:0]     opcode,
  input  logic [OP_W-1:0]      operand_a,
  input  logic [OP_W-1:0]      operand_b,
  input  logic                 clear_all,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*PW-1:0] read_pointer,
  output logic [NUM_RD*IW-1:0] instruction_word,
  output logic [NUM_RD-1:0]    valid,
  output logic [NVW-1:0]       num_valid
);

  logic [DEPTH-1:0][IW-1:0] mem_d, mem_q;
  logic [DEPTH-1:0]         vld_d, vld_q;
  logic [NVW-1:0]           cnt_d, cnt_q;
  logic [IW-1:0]            wr_word;
  logic                     wr_new;

  assign wr_word = {opcode, operand_a, operand_b};

  // Matching the pointer against each legal index drops out-of-range writes
  // naturally when DEPTH is not a power of two.
  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    wr_new = 1'b0;
    if (clear_all) begin
      vld_d = '0;
      cnt_d = '0;
    end else if (load_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (write_pointer == PW'(i)) begin
          mem_d[i] = wr_word;
          vld_d[i] = 1'b1;
          wr_new   = ~vld_q[i];
        end
      end
    end
    // Only a first write to an entry grows the count, so it cannot exceed DEPTH.
    if (wr_new) begin
      cnt_d = cnt_q + NVW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign num_valid = cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    instr_reg_rd_port #(
      .DEPTH (DEPTH),
      .PW    (PW),
      .IW    (IW)
    ) u_rd_port (
      .clk       (clk),
      .reset     (reset),
      .rd_en_i   (rd_en[k]),
      .rd_ptr_i  (read_pointer[k*PW +: PW]),
      .mem_i     (mem_q),
      .vld_i     (vld_q),
`ifdef INSTR_REG_WRITE_BYPASS_EN
      .wr_en_i   (load_en),
      .wr_ptr_i  (write_pointer),
      .wr_word_i (wr_word),
      .clear_i   (clear_all),
`endif
      .word_o    (instruction_word[k*IW +: IW]),
      .valid_o   (valid[k])
    );
  end

endmodule

// File: tb/tb_instr_reg_array.sv
// tb/tb_instr_reg_array.sv - directed self-checking bench for instr_reg_array (DEPTH 32 and DEPTH 20)
module tb_instr_reg_array;
  import instr_reg_pkg::*;

  localparam int IW = IW_DEFAULT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH=32 instance
  logic            reset, load_en, clear_all;
  logic [4:0]      write_pointer, opcode;
  logic [31:0]     operand_a, operand_b;
  logic [1:0]      rd_en, valid;
  logic [9:0]      read_pointer;
  logic [2*IW-1:0] instruction_word;
  logic [5:0]      num_valid;

  // DEPTH=20 instance
  logic            r20, le20, clr20;
  logic [4:0]      wp20, opc20;
  logic [31:0]     a20, b20;
  logic [1:0]      rd20, v20;
  logic [9:0]      rp20;
  logic [2*IW-1:0] w20;
  logic [4:0]      nv20;

  instr_reg_array #(.DEPTH(32), .NUM_RD(2)) u_dut (
    .clk(clk), .reset(reset), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .clear_all(clear_all), .rd_en(rd_en), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .valid(valid), .num_valid(num_valid)
  );

  instr_reg_array #(.DEPTH(20), .NUM_RD(2)) u_dut20 (
    .clk(clk), .reset(r20), .load_en(le20), .write_pointer(wp20),
    .opcode(opc20), .operand_a(a20), .operand_b(b20),
    .clear_all(clr20), .rd_en(rd20), .read_pointer(rp20),
    .instruction_word(w20), .valid(v20), .num_valid(nv20)
  );

  function automatic logic [IW-1:0] fill_word(input int i);
    return pack_instr(OPC_ADD, 32'(i) << 4, ~32'(i));
  endfunction

  task automatic wr32(input logic [4:0] p, input logic [IW-1:0] w);
    @(negedge clk);
    load_en = 1'b1; write_pointer = p;
    {opcode, operand_a, operand_b} = w;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic rd32(input logic [4:0] p0, input logic [4:0] p1);
    @(negedge clk);
    rd_en = 2'b11; read_pointer = {p1, p0};
    @(posedge clk); #1;
    rd_en = 2'b00;
  endtask

  task automatic wr20(input logic [4:0] p, input logic [IW-1:0] w);
    @(negedge clk);
    le20 = 1'b1; wp20 = p;
    {opc20, a20, b20} = w;
    @(posedge clk); #1;
    le20 = 1'b0;
  endtask

  task automatic rd20_2(input logic [4:0] p0, input logic [4:0] p1);
    @(negedge clk);
    rd20 = 2'b11; rp20 = {p1, p0};
    @(posedge clk); #1;
    rd20 = 2'b00;
  endtask

  task automatic test_reset;
    reset = 1'b1; r20 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (num_valid !== 6'd0 || valid !== 2'b00 || instruction_word !== '0) begin
      bad++;
      $display("FAIL reset_hold: nv=%0d valid=%b word=%h required nv=0 valid=00 word=0",
               num_valid, valid, instruction_word);
    end
    @(negedge clk);
    reset = 1'b0; r20 = 1'b0;
    rd32(5'd0, 5'd5);
    total++;
    if (valid !== 2'b00) begin
      bad++; $display("FAIL reset_read_valid: got %b required 00", valid);
    end
    total++;
    if (instruction_word !== '0) begin
      bad++; $display("FAIL reset_read_word: got %h required 0", instruction_word);
    end
    total++;
    if (num_valid !== 6'd0) begin
      bad++; $display("FAIL reset_num_valid: got %0d required 0", num_valid);
    end
  endtask

  task automatic test_write_dual_read;
    logic [IW-1:0] exp_w;
    exp_w = {5'h02, 32'h0000_0010, 32'hFFFF_FFF0};
    wr32(5'd3, pack_instr(OPC_SUB, 32'h0000_0010, 32'hFFFF_FFF0));
    rd32(5'd3, 5'd3);
    total++;
    if (instruction_word[IW-1:0] !== exp_w) begin
      bad++; $display("FAIL dual_read_ch0: got %h required %h", instruction_word[IW-1:0], exp_w);
    end
    total++;
    if (instruction_word[2*IW-1:IW] !== exp_w) begin
      bad++; $display("FAIL dual_read_ch1: got %h required %h", instruction_word[2*IW-1:IW], exp_w);
    end
    total++;
    if (valid !== 2'b11) begin
      bad++; $display("FAIL dual_read_valid: got %b required 11", valid);
    end
    total++;
    if (num_valid !== 6'd1) begin
      bad++; $display("FAIL dual_read_nv: got %0d required 1", num_valid);
    end
    // rd_en low: data holds, valid drops
    @(posedge clk); #1;
    total++;
    if (valid !== 2'b00 || instruction_word[IW-1:0] !== exp_w) begin
      bad++; $display("FAIL idle_hold: valid=%b word=%h required valid=00 word=%h",
                      valid, instruction_word[IW-1:0], exp_w);
    end
  endtask

  task automatic test_overwrite_fill;
    wr32(5'd3, pack_instr(OPC_OR, 32'h1111_1111, 32'h2222_2222));
    total++;
    if (num_valid !== 6'd1) begin
      bad++; $display("FAIL overwrite_nv: got %0d required 1", num_valid);
    end
    for (int i = 0; i < 32; i++) wr32(5'(i), fill_word(i));
    total++;
    if (num_valid !== 6'd32) begin
      bad++; $display("FAIL fill_nv: got %0d required 32", num_valid);
    end
    rd32(5'd31, 5'd0);
    total++;
    if (instruction_word !== {fill_word(0), fill_word(31)} || valid !== 2'b11) begin
      bad++; $display("FAIL fill_read: word=%h valid=%b required %h valid=11",
                      instruction_word, valid, {fill_word(0), fill_word(31)});
    end
  endtask

  task automatic test_clear_all;
    @(negedge clk);
    clear_all = 1'b1; load_en = 1'b1; write_pointer = 5'd7;
    {opcode, operand_a, operand_b} = pack_instr(OPC_JMP, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    @(posedge clk); #1;
    clear_all = 1'b0; load_en = 1'b0;
    total++;
    if (num_valid !== 6'd0) begin
      bad++; $display("FAIL clear_nv: got %0d required 0", num_valid);
    end
    rd32(5'd7, 5'd3);
    total++;
    if (valid !== 2'b00) begin
      bad++; $display("FAIL clear_read_valid: got %b required 00", valid);
    end
    // the dropped write must not have reached storage
    total++;
    if (instruction_word[IW-1:0] !== fill_word(7)) begin
      bad++; $display("FAIL clear_write_dropped: got %h required %h",
                      instruction_word[IW-1:0], fill_word(7));
    end
  endtask

  task automatic test_same_cycle;
    logic [IW-1:0] x_w, y_w, exp_w;
    x_w = pack_instr(OPC_LD, 32'hAAAA_0009, 32'h1234_5678);
    y_w = pack_instr(OPC_ST, 32'h5555_0009, 32'h8765_4321);
    wr32(5'd9, x_w);
    @(negedge clk);
    load_en = 1'b1; write_pointer = 5'd9;
    {opcode, operand_a, operand_b} = y_w;
    rd_en = 2'b01; read_pointer = {5'd0, 5'd9};
    @(posedge clk); #1;
    load_en = 1'b0; rd_en = 2'b00;
`ifdef INSTR_REG_WRITE_BYPASS_EN
    exp_w = y_w;
`else
    exp_w = x_w;
`endif
    total++;
    if (instruction_word[IW-1:0] !== exp_w || valid[0] !== 1'b1) begin
      bad++; $display("FAIL same_cycle_rw: word=%h valid=%b required %h valid=1",
                      instruction_word[IW-1:0], valid[0], exp_w);
    end
    total++;
    if (num_valid !== 6'd1) begin
      bad++; $display("FAIL same_cycle_nv: got %0d required 1", num_valid);
    end
    rd32(5'd9, 5'd9);
    total++;
    if (instruction_word !== {y_w, y_w} || valid !== 2'b11) begin
      bad++; $display("FAIL after_rw_read: word=%h valid=%b required %h valid=11",
                      instruction_word, valid, {y_w, y_w});
    end
`ifdef INSTR_REG_WRITE_BYPASS_EN
    @(negedge clk);
    clear_all = 1'b1; rd_en = 2'b11; read_pointer = {5'd9, 5'd9};
    @(posedge clk); #1;
    clear_all = 1'b0; rd_en = 2'b00;
    total++;
    if (valid !== 2'b00) begin
      bad++; $display("FAIL bypass_clear_valid: got %b required 00", valid);
    end
`endif
  endtask

  task automatic test_depth20;
    logic [IW-1:0] w3;
    w3 = pack_instr(OPC_AND, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
    wr20(5'd3, w3);
    wr20(5'd25, pack_instr(OPC_ADD, 32'h0000_0025, 32'h0000_0025));
    total++;
    if (nv20 !== 5'd1) begin
      bad++; $display("FAIL d20_oor_write_nv: got %0d required 1", nv20);
    end
    rd20_2(5'd25, 5'd3);
    total++;
    if (w20[IW-1:0] !== '0 || v20[0] !== 1'b0) begin
      bad++; $display("FAIL d20_oor_read: word=%h valid=%b required 0 valid=0", w20[IW-1:0], v20[0]);
    end
    total++;
    if (w20[2*IW-1:IW] !== w3 || v20[1] !== 1'b1) begin
      bad++; $display("FAIL d20_inrange_read: word=%h valid=%b required %h valid=1",
                      w20[2*IW-1:IW], v20[1], w3);
    end
    wr20(5'd19, fill_word(19));
    rd20_2(5'd19, 5'd20);
    total++;
    if (w20 !== {{IW{1'b0}}, fill_word(19)} || v20 !== 2'b01 || nv20 !== 5'd2) begin
      bad++; $display("FAIL d20_edge_read: word=%h valid=%b nv=%0d required %h valid=01 nv=2",
                      w20, v20, nv20, {{IW{1'b0}}, fill_word(19)});
    end
  endtask

  task automatic test_reset_mid_read;
    rd20_2(5'd3, 5'd3);
    @(negedge clk);
    rd20 = 2'b11; rp20 = {5'd3, 5'd3};
    #1 r20 = 1'b1;
    #1;
    total++;
    if (w20 !== '0 || v20 !== 2'b00 || nv20 !== 5'd0) begin
      bad++; $display("FAIL mid_reset_async: word=%h valid=%b nv=%0d required all 0", w20, v20, nv20);
    end
    @(posedge clk); #1;
    total++;
    if (w20 !== '0 || v20 !== 2'b00) begin
      bad++; $display("FAIL mid_reset_edge: word=%h valid=%b required all 0", w20, v20);
    end
    @(negedge clk);
    r20 = 1'b0; rd20 = 2'b00;
  endtask

  initial begin
    load_en = 1'b0; clear_all = 1'b0; write_pointer = '0; opcode = '0;
    operand_a = '0; operand_b = '0; rd_en = '0; read_pointer = '0;
    le20 = 1'b0; clr20 = 1'b0; wp20 = '0; opc20 = '0; a20 = '0; b20 = '0;
    rd20 = '0; rp20 = '0;
    test_reset;
    test_write_dual_read;
    test_overwrite_fill;
    test_clear_all;
    test_same_cycle;
    test_depth20;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_reg_array.md
Name: instr_reg_array

Overview:
- Parametrised successor to the instruction register: a DEPTH-entry array of instruction words {opcode, operand_a, operand_b}, with one write port and NUM_RD independent registered read channels.
- Tracks a valid bit per entry, keeps a live count of occupied entries, and supports a single-cycle invalidate-all.
- Sits between the instruction loader (write side) and the execution/checker stages (read side).
- Replaces the fixed-size, single-read-port version.

Parameters:
- DEPTH, 32, number of entries; any value from 2 to 256, power of two not required.
- OP_W, 32, width of each operand.
- OPC_W, 5, opcode width; must match the package opcode type.
- NUM_RD, 2, number of read channels (1 to 4).
- PW (derived, not overridable), $clog2(DEPTH), pointer width.
- IW (derived), OPC_W+2*OP_W, instruction word width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write strobe.
- write_pointer  in  PW  write index.
- opcode  in  OPC_W  write data, most significant field.
- operand_a  in  OP_W  write data, middle field.
- operand_b  in  OP_W  write data, least significant field.
- clear_all  in  1  invalidate all entries.
- rd_en  in  NUM_RD  per-channel read request.
- read_pointer  in  NUM_RD*PW  packed per-channel read index; channel k occupies bits [k*PW +: PW].
- instruction_word  out  NUM_RD*IW  packed read data; word layout {opcode, operand_a, operand_b}.
- valid  out  NUM_RD  per-channel: the read data came from a written entry.
- num_valid  out  $clog2(DEPTH+1)  count of valid entries.

Behaviour:
- Reset (asynchronous assert; release is synchronised by the reset source):
  - all storage, valid bits, instruction_word, valid and num_valid go to 0.
  - Reset asserted mid-operation aborts any in-flight read; outputs are 0 on the next observation.
- Write:
  - On a rising edge with load_en=1 and write_pointer<DEPTH, the entry is written with {opcode, operand_a, operand_b} and its valid bit is set.
  - num_valid increments only if that entry was previously invalid. Overwriting a valid entry leaves the count unchanged.
- Out-of-range write (write_pointer>=DEPTH, possible when DEPTH is not a power of two): ignored; no state change.
- clear_all:
  - On a rising edge with clear_all=1, all valid bits clear and num_valid becomes 0. Storage contents are retained but unreachable.
  - clear_all has priority over a simultaneous load_en: the write is dropped entirely (data not stored, valid not set).
- Read (per channel k, 1-cycle latency):
  - If rd_en[k]=1 at edge N, then after edge N: instruction_word[k] = entry[read_pointer[k]] and valid[k] = that entry's valid bit, both as they stood before edge N.
  - If rd_en[k]=0: instruction_word[k] holds its previous value and valid[k] goes to 0.
  - Out-of-range read_pointer with rd_en=1: instruction_word[k]=0, valid[k]=0.
- Multi-channel reads: channels are fully independent. Several channels may read the same entry in the same cycle, and each gets identical data.
- Same-cycle read and write to the same index (bypass macro undefined): the read returns the old contents and the old valid bit.
- num_valid range: never exceeds DEPTH; no wrap is possible.
- Implementation scope: no combinational path from any input to any output.

Optional Feature:
- Macro: INSTR_REG_WRITE_BYPASS_EN.
- Defined:
  - A same-cycle write to the index being read forwards the write data: instruction_word = new data, valid = 1.
  - A same-cycle clear_all forces valid[k]=0 for every channel reading that cycle, with or without a concurrent write.
- Undefined: read-before-write semantics as in Behaviour; no forwarding logic is generated.

Decomposition:
- Shared package instr_reg_pkg:
  - opcode_t enum sized by OPC_W_DEFAULT.
  - constants OPC_W_DEFAULT=5, OP_W_DEFAULT=32, DEPTH_DEFAULT=32.
  - a function packing {opcode, a, b} into an instruction word.
- In-module: the storage array and the valid bit vector. The instruction word type is parametrised, so it stays local to the module.
- Sub-module instr_reg_rd_port, instantiated NUM_RD times in a generate loop. It contains the range check, the optional bypass mux, and the output registers.

Test Plan (DEPTH=32, NUM_RD=2 unless stated):
- Reset, then read: assert reset for 3 cycles, release, then rd_en=2'b11 with pointers 0 and 5 -> valid=2'b00, instruction_word=0, num_valid=0.
- Write then dual read: write ptr 3 = {opc 5'h02, a=32'h0000_0010, b=32'hFFFF_FFF0}; next cycle read ptr 3 on both channels -> both words equal {5'h02, 32'h10, 32'hFFFFFFF0}, valid=2'b11, num_valid=1.
- Overwrite and fill: write ptr 3 twice -> num_valid stays 1; write all 32 indices -> num_valid=32.
- clear_all with simultaneous load to ptr 7:
  - next cycle num_valid=0;
  - a read of ptr 7 then gives valid=0;
  - a read of ptr 3 gives valid=0.
- Same-cycle read/write on ptr 9 (old value X, new value Y):
  - macro off -> channel returns X;
  - macro on -> channel returns Y with valid=1.
- DEPTH=20:
  - a write to ptr 25 is ignored, num_valid unchanged;
  - a read of ptr 25 gives word=0, valid=0;
  - reset asserted between a read request and its output cycle -> outputs 0.
